seg_scan_display: RTL and testbench
===================================

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 SHALL have parameter NBINS, default 8, number of FFT output bins per frame (power of two).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clk cycles per digit slot (1 kHz digit rate at 50 MHz).
REQ-003 SHALL have parameter DWELL_ROUNDS, default 250, full 4-digit scan rounds per displayed bin.
REQ-004 SHALL have ports as follows (one clock; reset asynchronous, active-low):
- clk  in  1  system clock, 50 MHz, rising edge
- rst  in  1  asynchronous active-low reset (0 = reset)
- bin_valid  in  1  FFT result beat valid
- bin_data  in  16  FFT bin magnitude, unsigned
- bin_last  in  1  marks final beat of a frame
- bin_ready  out  1  beat accepted when bin_valid & bin_ready
- frame_err  out  1  sticky: malformed frame seen
- cur_bin  out  log2(NBINS)  index of bin on display
- seg  out  7  segments, active-low, seg[6:0]=g,f,e,d,c,b,a
- an  out  4  digit anodes, active-low, an[3]=leftmost

Function
REQ-005 SHALL hold a write buffer and a display buffer, each NBINS x 16 bits.
REQ-006 SHALL drive bin_ready=1 in every cycle out of reset; a beat transfers on bin_valid & bin_ready at the clk edge.
REQ-007 SHALL write each accepted beat to write-buffer slot wr_ptr, then wr_ptr+1 (wrapping at NBINS).
REQ-008 SHALL, on an accepted beat with bin_last=1 and wr_ptr=NBINS-1, copy the write buffer (including the current beat) into the display buffer on that edge, then clear wr_ptr to 0.
REQ-009 SHALL, on an accepted beat with bin_last=1 and wr_ptr!=NBINS-1, discard the frame, clear wr_ptr to 0, set frame_err, and leave the display buffer unchanged.
REQ-010 SHALL, on an accepted beat with bin_last=0 and wr_ptr=NBINS-1, treat the beat as a malformed frame per REQ-009.
REQ-011 SHALL implement FSM states EMPTY (no valid frame yet) and SHOW; EMPTY->SHOW on the first swap per REQ-008; SHOW persists until reset.
REQ-012 SHALL, in EMPTY, drive an=4'b1111 and seg=7'b1111111 (blank).
REQ-013 SHALL run a refresh counter 0..REFRESH_DIV-1 continuously in both states; at terminal count it SHALL advance digit index 0->1->2->3->0.
REQ-014 SHALL, in SHOW, display digit index d as nibble d of display_buffer[cur_bin] (d=0 rightmost) with an=~(4'b0001<<d).
REQ-015 SHALL register seg and an, so they reflect a new digit index one clk after it changes.
REQ-016 SHALL decode nibbles 0-F (gfedcba, active-low) to 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-017 SHALL count rounds (digit index wrapping 3->0); after DWELL_ROUNDS rounds, cur_bin SHALL advance modulo NBINS and the round count SHALL clear.
REQ-018 SHALL, on every swap, set cur_bin=0 and clear the round count; when a swap and a dwell wrap occur on the same edge, the swap SHALL take precedence.
REQ-019 SHALL NOT reset the refresh counter or digit index on a swap; the digit scan stays uninterrupted.

Reset
REQ-020 SHALL, while rst=0, asynchronously set: state=EMPTY, wr_ptr=0, cur_bin=0, round and refresh counters=0, digit index=0, frame_err=0, bin_ready=0, an=4'b1111, seg=7'b1111111; buffer contents need not reset.
REQ-021 SHALL drop any partially received frame on reset, including a reset asserted mid-frame; bin_ready SHALL rise on the first clk edge after rst returns to 1.

Verification (REFRESH_DIV=4, DWELL_ROUNDS=2, NBINS=8)
REQ-022 SHALL cover: reset, no input -> an=1111, seg=1111111 indefinitely; frame_err=0; bin_ready=1 after release.
REQ-023 SHALL cover: frame 0x1234,0x0001..0x0007 with last on beat 8 -> cur_bin=0; an cycles 1110,1101,1011,0111 every 4 clks; seg shows 4,3,2,1 (0011001, 0110000, 0100100, 1111001).
REQ-024 SHALL cover: after REQ-023, wait 32 clks -> cur_bin=1, digits 1,0,0,0; after 256 clks total -> cur_bin wraps back to 0.
REQ-025 SHALL cover: 5 beats with last on beat 5 -> frame_err=1, display unchanged; next good frame of 0xABCD repeated -> seg shows d,C,b,A; frame_err stays 1.
REQ-026 SHALL cover: good frame whose final beat lands on the same edge as a dwell wrap -> cur_bin=0 with new data and round count cleared.
REQ-027 SHALL cover: rst=0 after beat 4 of a frame, then a full good frame -> display shows only the new frame; no stale-data swap occurs.

Source files
------------

// File: rtl/seg_scan_display.sv
// seg_scan_display
// Collects NBINS-beat FFT magnitude frames into a write buffer and, when a
// well-formed frame completes, copies it into a display buffer in one edge.
// A 4-digit multiplexed 7-segment display shows one bin at a time in hex.
// It dwells DWELL_ROUNDS full scan rounds on each bin before moving to the next.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   bin_valid  input beat valid
//   bin_data   16-bit unsigned bin magnitude
//   bin_last   final beat of a frame
//   bin_ready  beat accepted when bin_valid & bin_ready
//   frame_err  sticky flag: a malformed frame was seen
//   cur_bin    index of the bin currently on display
//   seg        segments g..a, active-low
//   an         digit anodes, active-low, an[3] = leftmost
//
// Handshake: a beat transfers on a rising edge where bin_valid and bin_ready
// are both 1. bin_ready is 0 in reset and 1 from the first edge after reset.
// It never drops afterwards, so the producer needs no back-pressure handling.
//
// The internal FSM state is state_q (EMPTY until the first good frame, then SHOW).
module seg_scan_display #(
  parameter int NBINS        = 8,
  parameter int REFRESH_DIV  = 50000,
  parameter int DWELL_ROUNDS = 250
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bin_valid,
  input  logic [15:0]              bin_data,
  input  logic                     bin_last,
  output logic                     bin_ready,
  output logic                     frame_err,
  output logic [$clog2(NBINS)-1:0] cur_bin,
  output logic [6:0]               seg,
  output logic [3:0]               an
);

  localparam int BW = $clog2(NBINS);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (DWELL_ROUNDS > 1) ? $clog2(DWELL_ROUNDS) : 1;

  typedef enum logic {EMPTY, SHOW} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   wr_ptr;
  logic [15:0]     wbuf [NBINS];
  logic [15:0]     dbuf [NBINS];
  logic [RW-1:0]   refresh_cnt;
  logic [1:0]      digit_idx;
  logic [DW-1:0]   round_cnt;
  logic [6:0]      seg_d;
  logic [3:0]      an_d;
  logic [15:0]     shown_word;
  logic [3:0]      nibble;

  logic accept, at_end, swap, bad;
  logic refresh_tc, round_tc, dwell_tc;

  assign accept = bin_valid & bin_ready;
  assign at_end = (wr_ptr == BW'(NBINS - 1));
  // A frame is good only if bin_last coincides exactly with the final slot.
  // Early last and missing last are both malformed.
  assign swap   = accept & bin_last & at_end;
  assign bad    = accept & (bin_last ^ at_end);

  assign refresh_tc = (refresh_cnt == RW'(REFRESH_DIV - 1));
  assign round_tc   = refresh_tc & (digit_idx == 2'd3);
  assign dwell_tc   = round_tc & (round_cnt == DW'(DWELL_ROUNDS - 1));

  assign shown_word = dbuf[cur_bin];
  assign nibble     = shown_word[{digit_idx, 2'b00} +: 4];

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  // Buffers carry no reset. A partial frame is discarded by clearing wr_ptr.
  // The display buffer is only ever read in SHOW.
  always_ff @(posedge clk) begin
    if (accept) wbuf[wr_ptr] <= bin_data;
    if (swap) begin
      for (int i = 0; i < NBINS; i++)
        dbuf[i] <= (i == NBINS - 1) ? bin_data : wbuf[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      wr_ptr      <= '0;
      bin_ready   <= 1'b0;
      frame_err   <= 1'b0;
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      round_cnt   <= '0;
      cur_bin     <= '0;
      seg         <= 7'b1111111;
      an          <= 4'b1111;
    end else begin
      state_q   <= state_d;
      bin_ready <= 1'b1;
      seg       <= seg_d;
      an        <= an_d;

      if (swap || bad)  wr_ptr <= '0;
      else if (accept)  wr_ptr <= wr_ptr + BW'(1);

      if (bad) frame_err <= 1'b1;

      // The scan never restarts on a swap, so digit brightness stays even.
      if (refresh_tc) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + RW'(1);
      end

      // A new frame always starts from bin 0 with a full dwell.
      // This overrides a dwell wrap on the same edge.
      if (swap) begin
        cur_bin   <= '0;
        round_cnt <= '0;
      end else if (dwell_tc) begin
        cur_bin   <= cur_bin + BW'(1);
        round_cnt <= '0;
      end else if (round_tc) begin
        round_cnt <= round_cnt + DW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    seg_d   = 7'b1111111;
    an_d    = 4'b1111;
    if (swap) state_d = SHOW;
    if (state_q == SHOW) begin
      an_d  = ~(4'b0001 << digit_idx);
      seg_d = hex_to_seg(nibble);
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

  localparam int NBINS      = 8;
  localparam int RDIV       = 4;
  localparam int DWELL      = 2;
  localparam int ROUND_CLKS = RDIV * 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bin_valid = 1'b0;
  logic [15:0] bin_data = 16'h0;
  logic        bin_last = 1'b0;
  logic        bin_ready, frame_err;
  logic [2:0]  cur_bin;
  logic [6:0]  seg;
  logic [3:0]  an;

  always #5 clk = ~clk;

  seg_scan_display #(.NBINS(NBINS), .REFRESH_DIV(RDIV), .DWELL_ROUNDS(DWELL)) dut (
    .clk(clk), .rst(rst), .bin_valid(bin_valid), .bin_data(bin_data),
    .bin_last(bin_last), .bin_ready(bin_ready), .frame_err(frame_err),
    .cur_bin(cur_bin), .seg(seg), .an(an)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Time is counted in clk edges since reset release (n).
  // Digit, round and dwell positions are plain arithmetic on n and on the
  // edge of the last swap (s).
  logic [6:0] dec [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  int          n = 0;
  int          s = 0;
  bit          shown = 0;
  bit          ready_m = 0;
  bit          err_m = 0;
  logic [15:0] fq [$];
  logic [15:0] dbuf_m [NBINS];
  logic [6:0]  exp_seg = 7'h7f;
  logic [3:0]  exp_an = 4'hf;

  function automatic int digit_at(input int e);
    return (e / RDIV) % 4;
  endfunction

  function automatic int bin_at(input int e);
    return ((e / ROUND_CLKS - s / ROUND_CLKS) / DWELL) % NBINS;
  endfunction

  // True when the coming edge ends a dwell period since the last swap.
  function automatic bit dwell_next();
    int e;
    int r;
    e = n + 1;
    r = e / ROUND_CLKS - s / ROUND_CLKS;
    return (e % ROUND_CLKS == 0) && (r > 0) && (r % DWELL == 0);
  endfunction

  task automatic model_step();
    int d;
    int w;
    if (!rst) begin
      n = 0; s = 0; shown = 0; ready_m = 0; err_m = 0;
      fq.delete();
      exp_seg = 7'h7f; exp_an = 4'hf;
    end else begin
      if (shown) begin
        d = digit_at(n);
        w = int'(dbuf_m[bin_at(n)]);
        exp_an  = 4'hF ^ (4'(1) << d);
        exp_seg = dec[(w >> (4 * d)) & 15];
      end else begin
        exp_seg = 7'h7f; exp_an = 4'hf;
      end
      n++;
      if (bin_valid && ready_m) begin
        fq.push_back(bin_data);
        if (bin_last || fq.size() == NBINS) begin
          if (bin_last && fq.size() == NBINS) begin
            for (int i = 0; i < NBINS; i++) dbuf_m[i] = fq[i];
            shown = 1;
            s = n;
          end else begin
            err_m = 1;
          end
          fq.delete();
        end
      end
      ready_m = 1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    model_step();
  end

  // ---------------- scoreboard: every cycle ----------------
  initial forever begin
    @(negedge clk);
    chk("bin_ready", bin_ready, ready_m);
    chk("frame_err", frame_err, err_m);
    chk("cur_bin", cur_bin, bin_at(n));
    chk("seg", seg, exp_seg);
    chk("an", an, exp_an);
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [15:0] d, input logic l);
    int w = 0;
    while (!bin_ready && w < 20) begin @(negedge clk); w++; end
    if (!bin_ready) chk("ready timeout", 0, 1);
    bin_valid = 1'b1; bin_data = d; bin_last = l;
    @(negedge clk);
    bin_valid = 1'b0; bin_last = 1'b0;
  endtask

  task automatic send_repeat_frame(input logic [15:0] d);
    for (int i = 0; i < NBINS; i++) send_beat(d, logic'(i == NBINS - 1));
  endtask

  // codes = {digit3, digit2, digit1, digit0}
  task automatic check_digits(input string tag, input logic [27:0] codes);
    logic [3:0] seen;
    seen = 4'h0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (an == (4'hF ^ (4'(1) << d))) begin
          chk({tag, " seg"}, seg, codes[7*d +: 7]);
          seen[d] = 1'b1;
        end
      end
    end
    chk({tag, " digits seen"}, seen, 4'hF);
  endtask

  task automatic wait_bin(input string tag, input int target, input int budget);
    int w = 0;
    while (cur_bin != 3'(target) && w < budget) begin @(negedge clk); w++; end
    chk(tag, cur_bin, target);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] data;
    logic [27:0] codes;
  } vec_t;

  vec_t tbl [4];

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int len;
    tbl[0] = '{16'h1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    tbl[1] = '{16'hABCD, {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}};
    tbl[2] = '{16'h5678, {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}};
    tbl[3] = '{16'h90EF, {7'b0010000, 7'b1000000, 7'b0000110, 7'b0001110}};

    // Reset, then idle: display stays blank.
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset bin_ready", bin_ready, 0);
    chk("reset an", an, 4'hf);
    chk("reset seg", seg, 7'h7f);
    #2 rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("idle an", an, 4'hf);
    chk("idle seg", seg, 7'h7f);
    chk("idle frame_err", frame_err, 0);
    chk("idle bin_ready", bin_ready, 1);

    // First good frame: bin 0 = 0x1234, bins 1..7 = 1..7.
    send_beat(16'h1234, 1'b0);
    for (int i = 1; i < NBINS; i++) send_beat(16'(i), logic'(i == NBINS - 1));
    chk("first frame cur_bin", cur_bin, 0);
    check_digits("bin0 1234", tbl[0].codes);

    // Dwell advance to bin 1 (0x0001), then wrap back to bin 0.
    wait_bin("dwell to bin1", 1, 40);
    check_digits("bin1 0001", {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111001});
    wait_bin("dwell to bin7", 7, 260);
    wait_bin("dwell wrap to bin0", 0, 40);

    // Short frame: flagged, display untouched.
    for (int i = 0; i < 5; i++) send_beat(16'hEEEE, logic'(i == 4));
    chk("short frame err", frame_err, 1);

    // Table-driven good frames, each bin repeating one value.
    foreach (tbl[t]) begin
      send_repeat_frame(tbl[t].data);
      chk("table cur_bin", cur_bin, 0);
      check_digits($sformatf("table %h", tbl[t].data), tbl[t].codes);
    end
    chk("err stays sticky", frame_err, 1);

    // Final beat of a good frame lands on a dwell wrap edge.
    for (int i = 0; i < NBINS - 1; i++) send_beat(16'h0100 + 16'(i), 1'b0);
    w = 0;
    while (!dwell_next() && w < 100) begin @(negedge clk); w++; end
    chk("dwell align", int'(dwell_next()), 1);
    send_beat(16'h0107, 1'b1);
    chk("swap beats dwell cur_bin", cur_bin, 0);
    repeat (20) @(negedge clk);
    chk("round cleared cur_bin", cur_bin, 0);

    // Reset in the middle of a frame, then a full good frame.
    for (int i = 0; i < 4; i++) send_beat(16'hDEAD, 1'b0);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midframe reset ready", bin_ready, 0);
    chk("midframe reset an", an, 4'hf);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("ready after release", bin_ready, 1);
    send_repeat_frame(16'h5678);
    check_digits("post reset 5678", tbl[2].codes);

    // Randomized frames: mostly well formed, some short or overlong.
    for (int f = 0; f < 30; f++) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : NBINS;
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_beat(16'($urandom), logic'(i == len - 1));
      end
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    repeat (300) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
